// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// with a start/busy/done handshake and a held sum/carry result register.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nxt;
    logic             c;
    logic             c_nxt;
    logic             s;
    logic [CW-1:0]    count;
    logic             last;
    logic             accept;

    // Full adder on the current LSBs; the new bit enters the partial sum at the MSB.
    assign s        = opa[0] ^ opb[0] ^ c;
    assign c_nxt    = (opa[0] & opb[0]) | (c & (opa[0] ^ opb[0]));
    assign psum_nxt = (psum >> 1) | (WIDTH'(s) << (WIDTH - 1));
    assign last     = (count == CW'(WIDTH - 1));
    assign accept   = start && (state == S_IDLE || state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_ADD;
            S_ADD:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_ADD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_ADD:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            psum  <= '0;
            c     <= 1'b0;
            count <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else if (accept) begin
            opa   <= A;
            opb   <= B;
            psum  <= '0;
            c     <= 1'b0;
            count <= '0;
        end else if (state == S_ADD) begin
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            psum  <= psum_nxt;
            c     <= c_nxt;
            count <= count + CW'(1);
            // Result register only moves on the completion edge.
            if (last) begin
                sum   <= psum_nxt;
                carry <= c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector tables, multi-cycle
// corner sequences, and random operands against an A+B reference model.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       carry8;
    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       carry1;

    int passed = 0;
    int total  = 0;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8),
        .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
        .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } vec8_t;

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } vec1_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    // Called at a negedge; drives one start cycle, returns at the next negedge.
    task automatic launch8(input logic [7:0] a, input logic [7:0] b);
        a8     = a;
        b8     = b;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8     = ~a;
        b8     = ~b;
    endtask

    // Counts remaining busy cycles, then checks the done cycle and the result.
    task automatic finish8(input string name, input int pre, input logic [7:0] es, input logic ec);
        int         n;
        logic       held;
        logic [7:0] ps;
        logic       pc;
        n    = pre;
        held = 1'b1;
        ps   = sum8;
        pc   = carry8;
        while (busy8 && n < 40) begin
            if (sum8 !== ps || carry8 !== pc || done8 !== 1'b0) held = 1'b0;
            n++;
            @(negedge clk);
        end
        check({name, " busy_cycles"}, n, 8);
        check({name, " held"}, held, 1);
        check({name, " done"}, {busy8, done8}, 2'b01);
        check({name, " sum"}, sum8, es);
        check({name, " carry"}, carry8, ec);
    endtask

    task automatic run1(input string name, input logic a, input logic b, input logic es, input logic ec);
        a1     = a;
        b1     = b;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check({name, " busy"}, {busy1, done1}, 2'b10);
        @(negedge clk);
        check({name, " done"}, {busy1, done1}, 2'b01);
        check({name, " sum"}, sum1, es);
        check({name, " carry"}, carry1, ec);
    endtask

    initial begin
        vec8_t      tab8[6];
        vec1_t      tab1[4];
        logic [8:0] model;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       saw_done;

        tab8[0] = '{8'h03, 8'h05, 8'h08, 1'b0};
        tab8[1] = '{8'hFF, 8'h01, 8'h00, 1'b1};
        tab8[2] = '{8'hFF, 8'hFF, 8'hFE, 1'b1};
        tab8[3] = '{8'h10, 8'h20, 8'h30, 1'b0};
        tab8[4] = '{8'h80, 8'h80, 8'h00, 1'b1};
        tab8[5] = '{8'h00, 8'h00, 8'h00, 1'b0};
        tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tab1[1] = '{1'b0, 1'b1, 1'b1, 1'b0};
        tab1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tab1[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

        rst_n  = 1'b0;
        start8 = 1'b0;
        start1 = 1'b0;
        a8     = 8'h00;
        b8     = 8'h00;
        a1     = 1'b0;
        b1     = 1'b0;
        @(negedge clk);
        check("reset w8", {busy8, done8, sum8, carry8}, 11'h0);
        check("reset w1", {busy1, done1, sum1, carry1}, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle w8", {busy8, done8}, 2'b00);

        for (int i = 0; i < 6; i++) begin
            launch8(tab8[i].a, tab8[i].b);
            check($sformatf("vec%0d busy_rise", i), {busy8, done8}, 2'b10);
            finish8($sformatf("vec%0d", i), 0, tab8[i].s, tab8[i].c);
            @(negedge clk);
            check($sformatf("vec%0d pulse_end", i), {busy8, done8}, 2'b00);
        end

        // Start during ADD must be ignored.
        launch8(8'h10, 8'h20);
        @(negedge clk);
        @(negedge clk);
        a8     = 8'hFF;
        b8     = 8'hFF;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        finish8("ignore_start", 3, 8'h30, 1'b0);
        @(negedge clk);

        // Back-to-back: start during the done cycle.
        launch8(8'h03, 8'h05);
        finish8("b2b_first", 0, 8'h08, 1'b0);
        launch8(8'h7F, 8'h01);
        check("b2b busy_rise", {busy8, done8}, 2'b10);
        finish8("b2b_second", 0, 8'h80, 1'b0);
        @(negedge clk);

        // Asynchronous reset mid-operation.
        launch8(8'h0F, 8'h01);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset outputs", {busy8, done8, sum8, carry8}, 11'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done8 || busy8) saw_done = 1'b1;
            @(negedge clk);
        end
        check("reset no_done", saw_done, 0);
        launch8(8'h01, 8'h01);
        finish8("after_reset", 0, 8'h02, 1'b0);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            run1($sformatf("w1_%0d", i), tab1[i].a, tab1[i].b, tab1[i].s, tab1[i].c);
            @(negedge clk);
        end

        for (int i = 0; i < 24; i++) begin
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            model = 9'(ra) + 9'(rb);
            launch8(ra, rb);
            finish8($sformatf("rand%0d %0h+%0h", i, ra, rb), 0, model[7:0], model[8]);
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
